// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - write-back bundle FIFO, two-write serialiser and pending scoreboard
module regfile_wb_sched #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(2*DEPTH+3)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [3:0]        wb_dstE_i,
  input  logic [DATA_W-1:0] wb_valE_i,
  input  logic [3:0]        wb_dstM_i,
  input  logic [DATA_W-1:0] wb_valM_i,
  output logic              rf_we_o,
  output logic [3:0]        rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic [3:0]        srcA_i,
  input  logic [3:0]        srcB_i,
  output logic              busyA_o,
  output logic              busyB_o,
  output logic [14:0]       pending_o,
  output logic              idle_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] NO_REG = 4'hf;

  typedef enum logic [1:0] {S_IDLE, S_WR_E, S_WR_M} state_t;

  logic [3:0]        fifo_dste [DEPTH];
  logic [DATA_W-1:0] fifo_vale [DEPTH];
  logic [3:0]        fifo_dstm [DEPTH];
  logic [DATA_W-1:0] fifo_valm [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic              accept, pop, fifo_empty;
  logic [3:0]        norm_dste;
  logic [3:0]        head_dste, head_dstm;
  logic [DATA_W-1:0] head_vale, head_valm;
  logic              head_e, head_m;

  state_t            state, state_nxt, head_state;
  logic [3:0]        m_dst;
  logic [DATA_W-1:0] m_val;
  logic              take_head, latch_m;
  logic              we_nxt;
  logic [3:0]        waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  assign fifo_empty = (count == '0);
  assign wb_ready_o = (count != (AW+1)'(DEPTH));
  assign accept     = wb_valid_i && wb_ready_o;
  // E and M to the same register: M wins, E is dropped before it is queued
  assign norm_dste  = (wb_dstE_i == wb_dstM_i) ? NO_REG : wb_dstE_i;

  assign head_dste = fifo_dste[rd_ptr];
  assign head_vale = fifo_vale[rd_ptr];
  assign head_dstm = fifo_dstm[rd_ptr];
  assign head_valm = fifo_valm[rd_ptr];
  assign head_e    = (head_dste != NO_REG);
  assign head_m    = (head_dstm != NO_REG);

  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_dste[wr_ptr] <= norm_dste;
      fifo_vale[wr_ptr] <= wb_valE_i;
      fifo_dstm[wr_ptr] <= wb_dstM_i;
      fifo_valm[wr_ptr] <= wb_valM_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= NO_REG;
      rf_wdata_o <= '0;
      m_dst      <= NO_REG;
      m_val      <= '0;
    end else begin
      state      <= state_nxt;
      rf_we_o    <= we_nxt;
      rf_waddr_o <= waddr_nxt;
      rf_wdata_o <= wdata_nxt;
      if (latch_m) begin
        m_dst <= head_dstm;
        m_val <= head_valm;
      end
    end
  end

  assign head_state = head_e ? S_WR_E : (head_m ? S_WR_M : S_IDLE);
  assign take_head  = !fifo_empty &&
                      ((state == S_IDLE) || (state == S_WR_M) ||
                       (state == S_WR_E && m_dst == NO_REG));
  assign pop        = take_head;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!fifo_empty) state_nxt = head_state;
      S_WR_E: begin
        if (m_dst != NO_REG)  state_nxt = S_WR_M;
        else if (!fifo_empty) state_nxt = head_state;
        else                  state_nxt = S_IDLE;
      end
      S_WR_M: begin
        if (!fifo_empty) state_nxt = head_state;
        else             state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    we_nxt    = 1'b0;
    waddr_nxt = rf_waddr_o;
    wdata_nxt = rf_wdata_o;
    latch_m   = 1'b0;
    if (state == S_WR_E && m_dst != NO_REG) begin
      we_nxt    = 1'b1;
      waddr_nxt = m_dst;
      wdata_nxt = m_val;
    end else if (take_head) begin
      if (head_e) begin
        we_nxt    = 1'b1;
        waddr_nxt = head_dste;
        wdata_nxt = head_vale;
        latch_m   = 1'b1;
      end else if (head_m) begin
        we_nxt    = 1'b1;
        waddr_nxt = head_dstm;
        wdata_nxt = head_valm;
      end
    end
  end

  // Normalisation guarantees at most one increment per register per accept
  for (genvar r = 0; r < 15; r++) begin : g_sb
    logic [CNT_W-1:0] cnt;
    logic             inc, dec;
    assign inc = accept && ((norm_dste == 4'(r)) || (wb_dstM_i == 4'(r)));
    assign dec = rf_we_o && (rf_waddr_o == 4'(r));
    always_ff @(posedge clk_i) begin
      if (rst_i) cnt <= '0;
      else       cnt <= cnt + CNT_W'(inc) - CNT_W'(dec);
    end
    assign pending_o[r] = (cnt != '0);
  end

  logic [15:0] pend_ext;
  assign pend_ext = {1'b0, pending_o};
  assign busyA_o  = pend_ext[srcA_i];
  assign busyB_o  = pend_ext[srcB_i];
  assign idle_o   = fifo_empty && (state == S_IDLE);

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - randomized and directed bench with a bundle-timeline reference model
module tb_regfile_wb_sched;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              wb_valid_i = 1'b0;
  logic              wb_ready_o;
  logic [3:0]        wb_dstE_i = 4'hf;
  logic [DATA_W-1:0] wb_valE_i = '0;
  logic [3:0]        wb_dstM_i = 4'hf;
  logic [DATA_W-1:0] wb_valM_i = '0;
  logic              rf_we_o;
  logic [3:0]        rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;
  logic [3:0]        srcA_i = 4'hf;
  logic [3:0]        srcB_i = 4'hf;
  logic              busyA_o, busyB_o;
  logic [14:0]       pending_o;
  logic              idle_o;

  regfile_wb_sched #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_dstE_i(wb_dstE_i), .wb_valE_i(wb_valE_i),
    .wb_dstM_i(wb_dstM_i), .wb_valM_i(wb_valM_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .srcA_i(srcA_i), .srcB_i(srcB_i),
    .busyA_o(busyA_o), .busyB_o(busyB_o),
    .pending_o(pending_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Each accepted bundle: accept edge a, pop edge p, w writes occupying cycles p..p+w-1
  typedef struct {
    int          a;
    int          p;
    int          w;
    logic [3:0]  d0, d1;
    logic [63:0] v0, v1;
  } bun_t;

  bun_t bq[$];
  int   n = 0;
  int   server_free = 0;
  int   last_end = 0;
  bit   started = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, n, obs, exp);
    end
  endtask

  function automatic int model_occ();
    int occ = 0;
    foreach (bq[i]) if (bq[i].p > n) occ++;
    return occ;
  endfunction

  task automatic add_bundle();
    bun_t b;
    logic [3:0] de;
    de = wb_dstE_i;
    if (wb_dstE_i == wb_dstM_i && wb_dstE_i != 4'hf) de = 4'hf;
    b.a = n; b.w = 0;
    b.d0 = 4'hf; b.d1 = 4'hf; b.v0 = '0; b.v1 = '0;
    if (de != 4'hf) begin b.d0 = de; b.v0 = wb_valE_i; b.w = 1; end
    if (wb_dstM_i != 4'hf) begin
      if (b.w == 0) begin b.d0 = wb_dstM_i; b.v0 = wb_valM_i; end
      else begin b.d1 = wb_dstM_i; b.v1 = wb_valM_i; end
      b.w++;
    end
    b.p = (n + 1 > server_free) ? n + 1 : server_free;
    server_free = b.p + ((b.w == 0) ? 1 : b.w);
    last_end = b.p + b.w;
    bq.push_back(b);
  endtask

  task automatic check_all();
    int occ;
    int cnt[16];
    logic        exp_we = 1'b0;
    logic [3:0]  exp_a = 4'hf;
    logic [63:0] exp_d = '0;
    logic [14:0] exp_pend = '0;
    while (bq.size() > 0 && n >= bq[0].p + bq[0].w && n >= bq[0].p) void'(bq.pop_front());
    occ = model_occ();
    foreach (cnt[i]) cnt[i] = 0;
    foreach (bq[i]) begin
      for (int k = 0; k < bq[i].w; k++) begin
        if (n < bq[i].p + k + 1) cnt[(k == 0) ? bq[i].d0 : bq[i].d1]++;
        if (n == bq[i].p + k) begin
          exp_we = 1'b1;
          exp_a  = (k == 0) ? bq[i].d0 : bq[i].d1;
          exp_d  = (k == 0) ? bq[i].v0 : bq[i].v1;
        end
      end
    end
    for (int r = 0; r < 15; r++) exp_pend[r] = (cnt[r] != 0);
    check("ready", 64'(wb_ready_o), 64'(occ < DEPTH));
    check("idle", 64'(idle_o), 64'(occ == 0 && n >= last_end));
    check("rf_we", 64'(rf_we_o), 64'(exp_we));
    if (exp_we) begin
      check("rf_waddr", 64'(rf_waddr_o), 64'(exp_a));
      check("rf_wdata", rf_wdata_o, exp_d);
    end
    check("pending", 64'(pending_o), 64'(exp_pend));
    check("busyA", 64'(busyA_o), 64'(srcA_i != 4'hf && cnt[srcA_i] != 0));
    check("busyB", 64'(busyB_o), 64'(srcB_i != 4'hf && cnt[srcB_i] != 0));
  endtask

  task automatic tick(output bit acc);
    acc = !rst_i && wb_valid_i && (model_occ() < DEPTH);
    @(posedge clk_i);
    n++;
    if (rst_i) begin
      bq.delete();
      server_free = 0;
      last_end = 0;
      started = 1;
    end else if (acc) begin
      add_bundle();
    end
    @(negedge clk_i);
    if (started) check_all();
  endtask

  task automatic idle_cycles(input int k);
    bit acc;
    wb_valid_i = 1'b0;
    repeat (k) tick(acc);
  endtask

  task automatic send(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
    bit acc = 0;
    wb_valid_i = 1'b1;
    wb_dstE_i = de; wb_valE_i = ve;
    wb_dstM_i = dm; wb_valM_i = vm;
    for (int t = 0; t < 50 && !acc; t++) tick(acc);
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic do_reset();
    bit acc;
    rst_i = 1'b1;
    wb_valid_i = 1'b0;
    tick(acc);
    rst_i = 1'b0;
    check("rst_waddr", 64'(rf_waddr_o), 64'hf);
    check("rst_wdata", rf_wdata_o, 64'd0);
  endtask

  function automatic logic [3:0] rand_reg();
    return 4'($urandom_range(0, 14));
  endfunction

  function automatic logic [63:0] rand_val();
    return {$urandom, $urandom};
  endfunction

  initial begin
    bit acc;
    logic [3:0] a, b;
    @(negedge clk_i);
    do_reset();
    do_reset();

    srcA_i = 4'd3; srcB_i = 4'd5;
    send(4'd3, 64'h11, 4'd5, 64'h22);
    idle_cycles(6);

    srcA_i = 4'd4; srcB_i = 4'hf;
    send(4'd4, 64'hAA, 4'd4, 64'hBB);
    idle_cycles(5);

    for (int i = 0; i < 6; i++) begin
      a = rand_reg();
      b = (a == 4'd14) ? 4'd0 : a + 4'd1;
      send(a, rand_val(), b, rand_val());
    end
    for (int i = 0; i < 10; i++) send(rand_reg(), rand_val(), rand_reg(), rand_val());
    idle_cycles(30);

    send(4'd1, rand_val(), 4'd2, rand_val());
    send(4'hf, rand_val(), 4'hf, rand_val());
    send(4'd6, rand_val(), 4'hf, rand_val());
    send(4'hf, rand_val(), 4'hf, rand_val());
    send(4'hf, rand_val(), 4'd9, rand_val());
    idle_cycles(10);

    srcA_i = 4'd7; srcB_i = 4'hf;
    send(4'd7, rand_val(), 4'd8, rand_val());
    send(4'd2, rand_val(), 4'd7, rand_val());
    idle_cycles(10);

    for (int i = 0; i < 6; i++) send(rand_reg(), rand_val(), rand_reg(), rand_val());
    do_reset();
    idle_cycles(12);

    for (int i = 0; i < 400; i++) begin
      wb_valid_i = ($urandom_range(0, 2) != 0);
      wb_dstE_i  = ($urandom_range(0, 3) == 0) ? 4'hf : rand_reg();
      wb_dstM_i  = ($urandom_range(0, 3) == 0) ? 4'hf : rand_reg();
      if ($urandom_range(0, 7) == 0) wb_dstM_i = wb_dstE_i;
      wb_valE_i  = rand_val();
      wb_valM_i  = rand_val();
      srcA_i     = 4'($urandom_range(0, 15));
      srcB_i     = 4'($urandom_range(0, 15));
      rst_i      = ($urandom_range(0, 99) == 0);
      tick(acc);
    end
    rst_i = 1'b0;
    idle_cycles(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
